instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch-and-decode stage directly upstream of the program counter. It holds the instruction memory and reads it combinationally at the current `pc`. It drives the opcode, immediate value and register select that the PC, the register file and the ALU consume in the same cycle. It also sequences power-up: it holds the core in RESET, optionally accepts a program download, then runs, and freezes the core on HALT until resumed.

## Interface
- `OPCODE_WIDTH`, 4: opcode field width; encodings (RESET, NOP, JUMP, HALT, ...) come from the shared parameters header.
- `VALUE_WIDTH`, 8: immediate field width.
- `REG_SEL_WIDTH`, 2: register-select field width.
- `PC_WIDTH`, 8: address width; memory depth is fixed at 2**PC_WIDTH words.
- `RESET_CYCLES`, 2: cycles RESET is driven after `reset` deasserts (1..15).
- `clock` in 1: single clock; everything updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `pc` in PC_WIDTH: current program counter.
- `loadEnable` in 1: request download mode.
- `loadValid` in 1: write strobe for one instruction word.
- `loadAddr` in PC_WIDTH: write address.
- `loadData` in OPCODE_WIDTH+REG_SEL_WIDTH+VALUE_WIDTH: instruction word.
- `loadReady` out 1: high while in LOAD.
- `resume` in 1: leave HALTED.
- `opcode` out OPCODE_WIDTH: feeds the PC's opcode/reset-code input.
- `instructionValue` out VALUE_WIDTH: immediate / jump target.
- `registerSelect` out REG_SEL_WIDTH: register-file read select.
- `halted` out 1: high in HALTED.
- `instrCount` out 32: executed-instruction count (see Configuration).

## Operation
- Instruction word layout, MSB first: {opcode, registerSelect, value}.
- Memory write is synchronous; read is combinational at `pc`. Memory is not reset.
- States:
  - RESET_HOLD:
    - `opcode` = RESET; value = 0; registerSelect = 0.
    - Counter increments each cycle.
    - When the counter reaches RESET_CYCLES-1, go to LOAD if `loadEnable`, else RUN.
  - LOAD:
    - `opcode` = RESET, which keeps pc at 0; `loadReady` = 1.
    - Each cycle with `loadValid`, write mem[loadAddr] = loadData.
    - Go to RUN when `loadEnable` = 0. A `loadValid` in that same cycle is still written.
  - RUN:
    - Outputs are the fields of mem[pc].
    - If the fetched opcode is HALT, drive `opcode` = JUMP with value = pc instead (pc holds) and go to HALTED.
    - `resume` is ignored.
  - HALTED:
    - `halted` = 1.
    - Drive JUMP with value = pc each cycle.
    - On `resume`, drive NOP this cycle (pc advances past the HALT) and go to RUN.
- `loadValid` outside LOAD is ignored. `loadEnable` sampled outside RESET_HOLD exit is ignored; re-entry to LOAD requires `reset`.
- `instructionValue` is zero-extended or truncated to PC_WIDTH by the consumer. This block drives exactly VALUE_WIDTH bits.

## Timing
- Reset values: state RESET_HOLD, counter 0, `opcode` RESET, `instructionValue` 0, `registerSelect` 0, `loadReady` 0, `halted` 0, `instrCount` 0.
- `reset` mid-operation (any state): the write in that cycle is suppressed. RESET_HOLD starts the next cycle with the counter at 0.
- Outputs are combinational from state and memory, with zero latency from `pc`.
- The first RUN cycle follows the last RESET_HOLD or LOAD cycle. The PC then presents 0, so instruction 0 is decoded in the first RUN cycle.
- A memory write is visible to a read in the cycle after the write edge.
- HALT decoded in cycle n: HALTED from n+1. `resume` in cycle m: RUN from m+1, with pc = HALT address + 1.

## Configuration
- `FETCH_INSTR_COUNT_EN` defined:
  - `instrCount` increments by 1 (wrapping at 2^32) every RUN cycle and every resume cycle.
  - It is not incremented in RESET_HOLD, LOAD or HALTED, and clears on `reset`.
- Not defined: counter logic is absent and `instrCount` is tied to 0.

## Test plan
- Reset with RESET_CYCLES=2, `loadEnable`=0 -> `opcode`=RESET for exactly 2 cycles after `reset` falls, then RUN with `pc`=0 decoded.
- Download: write words to addresses 0..3 in LOAD (`loadReady`=1), drop `loadEnable` with a final `loadValid` to address 4 in the same cycle -> mem[4] is written; RUN fetches the word at address 0 first.
- Word {JUMP, 2'd0, 8'h10} at pc 0x05 -> `opcode`=JUMP, `instructionValue`=0x10, `registerSelect`=0, in the same cycle.
- HALT at pc 0x07 -> JUMP to 0x07 each cycle, `halted`=1 from the next cycle; `resume` pulse -> NOP that cycle, `halted`=0 next cycle, pc reaches 0x08.
- `reset` asserted mid-LOAD together with `loadValid` to address 9 -> mem[9] unchanged; RESET_HOLD is re-entered.
- With `FETCH_INSTR_COUNT_EN`: 5 RUN cycles, HALT, 3 HALTED cycles, resume -> `instrCount`=6 after the resume edge. Without the macro, `instrCount`=0 throughout.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: instruction memory, field decode and RESET/LOAD/RUN/HALTED sequencing ahead of the PC.
// Optional macro FETCH_INSTR_COUNT_EN enables the executed-instruction counter on instrCount.
module instruction_fetch #(
    parameter int unsigned OPCODE_WIDTH  = 4,
    parameter int unsigned VALUE_WIDTH   = 8,
    parameter int unsigned REG_SEL_WIDTH = 2,
    parameter int unsigned PC_WIDTH      = 8,
    parameter int unsigned RESET_CYCLES  = 2,
    parameter logic [OPCODE_WIDTH-1:0] OP_RESET = OPCODE_WIDTH'(0),
    parameter logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(1),
    parameter logic [OPCODE_WIDTH-1:0] OP_JUMP  = OPCODE_WIDTH'(2),
    parameter logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(3)
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [PC_WIDTH-1:0]                           pc,
    input  logic                                          loadEnable,
    input  logic                                          loadValid,
    input  logic [PC_WIDTH-1:0]                           loadAddr,
    input  logic [OPCODE_WIDTH+REG_SEL_WIDTH+VALUE_WIDTH-1:0] loadData,
    output logic                                          loadReady,
    input  logic                                          resume,
    output logic [OPCODE_WIDTH-1:0]                       opcode,
    output logic [VALUE_WIDTH-1:0]                        instructionValue,
    output logic [REG_SEL_WIDTH-1:0]                      registerSelect,
    output logic                                          halted,
    output logic [31:0]                                   instrCount
);

    localparam int unsigned WORD_WIDTH = OPCODE_WIDTH + REG_SEL_WIDTH + VALUE_WIDTH;
    localparam int unsigned DEPTH      = 2 ** PC_WIDTH;
    localparam int unsigned HOLD_WIDTH = 4;
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RESET_HOLD = 2'd0,
        S_LOAD       = 2'd1,
        S_RUN        = 2'd2,
        S_HALTED     = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [HOLD_WIDTH-1:0]   r_hold_cnt;
    logic [HOLD_WIDTH-1:0]   w_hold_cnt_next;

    logic [WORD_WIDTH-1:0]    r_mem [DEPTH];
    logic [WORD_WIDTH-1:0]    w_word;
    logic [OPCODE_WIDTH-1:0]  w_fetch_op;
    logic [REG_SEL_WIDTH-1:0] w_fetch_rs;
    logic [VALUE_WIDTH-1:0]   w_fetch_val;
    logic [VALUE_WIDTH-1:0]   w_pc_value;
    logic                     w_mem_we;

    // Word layout is {opcode, registerSelect, value}, read combinationally at pc.
    assign w_word      = r_mem[pc];
    assign w_fetch_op  = w_word[WORD_WIDTH-1 -: OPCODE_WIDTH];
    assign w_fetch_rs  = w_word[VALUE_WIDTH +: REG_SEL_WIDTH];
    assign w_fetch_val = w_word[VALUE_WIDTH-1:0];
    assign w_pc_value  = VALUE_WIDTH'(pc);

    // A reset in the same cycle cancels the download write.
    assign w_mem_we = (r_state == S_LOAD) && loadValid && !reset;

    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[loadAddr] <= loadData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_RESET_HOLD;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_cnt_next;
        end
    end

    // Next state and decode; HALT is turned into a self-jump so the PC holds.
    always_comb begin
        w_state_next     = r_state;
        w_hold_cnt_next  = r_hold_cnt;
        opcode           = OP_RESET;
        instructionValue = '0;
        registerSelect   = '0;
        loadReady        = 1'b0;
        halted           = 1'b0;
        case (r_state)
            S_RESET_HOLD: begin
                w_hold_cnt_next = r_hold_cnt + HOLD_WIDTH'(1);
                if (r_hold_cnt == HOLD_LAST) begin
                    w_hold_cnt_next = '0;
                    w_state_next    = loadEnable ? S_LOAD : S_RUN;
                end
            end
            S_LOAD: begin
                loadReady = 1'b1;
                if (!loadEnable) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_fetch_op == OP_HALT) begin
                    opcode           = OP_JUMP;
                    instructionValue = w_pc_value;
                    w_state_next     = S_HALTED;
                end else begin
                    opcode           = w_fetch_op;
                    instructionValue = w_fetch_val;
                    registerSelect   = w_fetch_rs;
                end
            end
            S_HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    opcode       = OP_NOP;
                    w_state_next = S_RUN;
                end else begin
                    opcode           = OP_JUMP;
                    instructionValue = w_pc_value;
                end
            end
            default: begin
                w_state_next = S_RESET_HOLD;
            end
        endcase
    end

`ifdef FETCH_INSTR_COUNT_EN
    logic [31:0] r_instr_count;
    logic        w_retire;

    assign w_retire = (r_state == S_RUN) || ((r_state == S_HALTED) && resume);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr_count <= '0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign instrCount = r_instr_count;
`else
    assign instrCount = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table with scoreboard queue, plus a closed-loop PC sequence.
module tb_instruction_fetch;

    localparam int unsigned OW = 4;
    localparam int unsigned VW = 8;
    localparam int unsigned RW = 2;
    localparam int unsigned PW = 8;
    localparam int unsigned WW = OW + RW + VW;

    localparam logic [OW-1:0] OP_RESET = 4'h0;
    localparam logic [OW-1:0] OP_NOP   = 4'h1;
    localparam logic [OW-1:0] OP_JUMP  = 4'h2;
    localparam logic [OW-1:0] OP_HALT  = 4'h3;
    localparam logic [OW-1:0] OP_ALU   = 4'h5;

`ifdef FETCH_INSTR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [PW-1:0] pc;
    logic          loadEnable;
    logic          loadValid;
    logic [PW-1:0] loadAddr;
    logic [WW-1:0] loadData;
    logic          loadReady;
    logic          resume;
    logic [OW-1:0] opcode;
    logic [VW-1:0] instructionValue;
    logic [RW-1:0] registerSelect;
    logic          halted;
    logic [31:0]   instrCount;

    always #5 clock = ~clock;

    instruction_fetch #(
        .OPCODE_WIDTH (OW),
        .VALUE_WIDTH  (VW),
        .REG_SEL_WIDTH(RW),
        .PC_WIDTH     (PW),
        .RESET_CYCLES (2),
        .OP_RESET     (OP_RESET),
        .OP_NOP       (OP_NOP),
        .OP_JUMP      (OP_JUMP),
        .OP_HALT      (OP_HALT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pc              (pc),
        .loadEnable      (loadEnable),
        .loadValid       (loadValid),
        .loadAddr        (loadAddr),
        .loadData        (loadData),
        .loadReady       (loadReady),
        .resume          (resume),
        .opcode          (opcode),
        .instructionValue(instructionValue),
        .registerSelect  (registerSelect),
        .halted          (halted),
        .instrCount      (instrCount)
    );

    typedef struct {
        logic          rst;
        logic [PW-1:0] pc;
        logic          le;
        logic          lv;
        logic [PW-1:0] la;
        logic [WW-1:0] ld;
        logic          res;
        logic [OW-1:0] op;
        logic [VW-1:0] val;
        logic [RW-1:0] rs;
        logic          rdy;
        logic          hlt;
        logic [31:0]   cnt;
    } vec_t;

    typedef struct {
        int            idx;
        logic [OW-1:0] op;
        logic [VW-1:0] val;
        logic [RW-1:0] rs;
        logic          rdy;
        logic          hlt;
        logic [31:0]   cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [WW-1:0] w(input logic [OW-1:0] op, input logic [RW-1:0] rs,
                                        input logic [VW-1:0] val);
        return {op, rs, val};
    endfunction

    function automatic void add(input logic rst, input logic [PW-1:0] p, input logic le,
                                input logic lv, input logic [PW-1:0] la, input logic [WW-1:0] ld,
                                input logic res, input logic [OW-1:0] op, input logic [VW-1:0] val,
                                input logic [RW-1:0] rs, input logic rdy, input logic hlt,
                                input logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.pc = p; v.le = le; v.lv = lv; v.la = la; v.ld = ld; v.res = res;
        v.op = op; v.val = val; v.rs = rs; v.rdy = rdy; v.hlt = hlt; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    function automatic logic [PW-1:0] next_pc(input logic [OW-1:0] op, input logic [VW-1:0] val,
                                              input logic [PW-1:0] cur);
        if (op == OP_RESET) return '0;
        if (op == OP_JUMP)  return PW'(val);
        return cur + PW'(1);
    endfunction

    task automatic cmp(input int idx, input string f, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL vec%0d %s: got %0h want %0h", idx, f, got, want);
        end
    endtask

    task automatic check_top();
        exp_t e;
        e = sb.pop_front();
        cmp(e.idx, "opcode",    32'(opcode),           32'(e.op));
        cmp(e.idx, "value",     32'(instructionValue), 32'(e.val));
        cmp(e.idx, "regsel",    32'(registerSelect),   32'(e.rs));
        cmp(e.idx, "loadReady", 32'(loadReady),        32'(e.rdy));
        cmp(e.idx, "halted",    32'(halted),           32'(e.hlt));
        cmp(e.idx, "instrCount", instrCount, CNT_EN ? e.cnt : 32'd0);
    endtask

    task automatic build_vectors();
        // Reset into LOAD: RESET for exactly two cycles after reset falls.
        add(1, 8'h00, 1, 0, 8'h00, '0, 0, OP_RESET, 8'h00, 2'd0, 0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h00, '0, 0, OP_RESET, 8'h00, 2'd0, 0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h00, '0, 0, OP_RESET, 8'h00, 2'd0, 0, 0, 0);
        // Download; final word to address 4 lands in the cycle loadEnable drops.
        add(0, 8'h00, 1, 1, 8'h00, w(OP_NOP,  2'd1, 8'h11), 0, OP_RESET, 8'h00, 2'd0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 8'h01, w(OP_ALU,  2'd2, 8'h22), 0, OP_RESET, 8'h00, 2'd0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 8'h02, w(OP_NOP,  2'd3, 8'h33), 0, OP_RESET, 8'h00, 2'd0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 8'h03, w(OP_NOP,  2'd0, 8'h44), 0, OP_RESET, 8'h00, 2'd0, 1, 0, 0);
        add(0, 8'h00, 1, 0, 8'h06, w(OP_HALT, 2'd0, 8'h00), 0, OP_RESET, 8'h00, 2'd0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 8'h05, w(OP_JUMP, 2'd0, 8'h10), 0, OP_RESET, 8'h00, 2'd0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 8'h07, w(OP_HALT, 2'd0, 8'h00), 0, OP_RESET, 8'h00, 2'd0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 8'h08, w(OP_NOP,  2'd1, 8'h88), 0, OP_RESET, 8'h00, 2'd0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 8'h10, w(OP_JUMP, 2'd0, 8'h07), 0, OP_RESET, 8'h00, 2'd0, 1, 0, 0);
        add(0, 8'h00, 1, 1, 8'h09, w(OP_NOP,  2'd2, 8'h99), 0, OP_RESET, 8'h00, 2'd0, 1, 0, 0);
        add(0, 8'h00, 0, 1, 8'h04, w(OP_HALT, 2'd0, 8'h00), 0, OP_RESET, 8'h00, 2'd0, 1, 0, 0);
        // RUN: stray loadValid/loadEnable/resume are ignored; HALT at 4 then resume.
        add(0, 8'h00, 0, 1, 8'h00, w(OP_JUMP, 2'd3, 8'hFF), 0, OP_NOP,  8'h11, 2'd1, 0, 0, 0);
        add(0, 8'h01, 1, 0, 8'h00, '0, 0, OP_ALU,  8'h22, 2'd2, 0, 0, 1);
        add(0, 8'h02, 0, 0, 8'h00, '0, 0, OP_NOP,  8'h33, 2'd3, 0, 0, 2);
        add(0, 8'h03, 0, 0, 8'h00, '0, 1, OP_NOP,  8'h44, 2'd0, 0, 0, 3);
        add(0, 8'h04, 0, 0, 8'h00, '0, 0, OP_JUMP, 8'h04, 2'd0, 0, 0, 4);
        add(0, 8'h04, 0, 0, 8'h00, '0, 0, OP_JUMP, 8'h04, 2'd0, 0, 1, 5);
        add(0, 8'h04, 0, 0, 8'h00, '0, 0, OP_JUMP, 8'h04, 2'd0, 0, 1, 5);
        add(0, 8'h04, 0, 0, 8'h00, '0, 1, OP_NOP,  8'h00, 2'd0, 0, 1, 5);
        add(0, 8'h05, 0, 0, 8'h00, '0, 0, OP_JUMP, 8'h10, 2'd0, 0, 0, 6);
        add(0, 8'h10, 0, 0, 8'h00, '0, 0, OP_JUMP, 8'h07, 2'd0, 0, 0, 7);
        add(0, 8'h07, 0, 0, 8'h00, '0, 0, OP_JUMP, 8'h07, 2'd0, 0, 0, 8);
        add(0, 8'h07, 0, 0, 8'h00, '0, 0, OP_JUMP, 8'h07, 2'd0, 0, 1, 9);
        add(0, 8'h07, 0, 0, 8'h00, '0, 1, OP_NOP,  8'h00, 2'd0, 0, 1, 9);
        add(0, 8'h08, 0, 0, 8'h00, '0, 0, OP_NOP,  8'h88, 2'd1, 0, 0, 10);
        add(0, 8'h09, 0, 0, 8'h00, '0, 0, OP_NOP,  8'h99, 2'd2, 0, 0, 11);
        // Reset from RUN into LOAD, then reset mid-LOAD with a write to 9 that must be dropped.
        add(1, 8'h09, 1, 0, 8'h00, '0, 0, OP_NOP,  8'h99, 2'd2, 0, 0, 12);
        add(0, 8'h00, 1, 0, 8'h00, '0, 0, OP_RESET, 8'h00, 2'd0, 0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h00, '0, 0, OP_RESET, 8'h00, 2'd0, 0, 0, 0);
        add(1, 8'h00, 1, 1, 8'h09, w(OP_JUMP, 2'd3, 8'hEE), 0, OP_RESET, 8'h00, 2'd0, 1, 0, 0);
        add(0, 8'h00, 0, 0, 8'h00, '0, 0, OP_RESET, 8'h00, 2'd0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 8'h00, '0, 0, OP_RESET, 8'h00, 2'd0, 0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h00, '0, 0, OP_NOP,  8'h11, 2'd1, 0, 0, 0);
        add(0, 8'h09, 0, 0, 8'h00, '0, 0, OP_NOP,  8'h99, 2'd2, 0, 0, 1);
    endtask

    // Closed loop with a PC model: run to the HALT at 7 via 4, resume, and land on 8.
    task automatic closed_loop();
        logic [PW-1:0] pcm;
        logic [PW-1:0] nxt;
        bit            found;
        pcm = '0; found = 1'b0;
        reset = 1'b1; loadEnable = 1'b0; loadValid = 1'b0; resume = 1'b0; pc = '0;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            pc     = pcm;
            resume = halted && (pcm == 8'h04);
            #1;
            if (halted && pcm == 8'h07) begin
                found = 1'b1;
            end else begin
                nxt = next_pc(opcode, instructionValue, pcm);
                @(posedge clock); #1;
                resume = 1'b0;
                pcm = nxt;
            end
        end
        cmp(100, "halt7_reached", 32'(found), 32'd1);
        cmp(101, "halt7_opcode", 32'(opcode), 32'(OP_JUMP));
        cmp(102, "halt7_value", 32'(instructionValue), 32'h07);
        @(posedge clock); #1;
        pc = pcm;
        #1;
        cmp(103, "halt7_hold_pc", 32'(next_pc(opcode, instructionValue, pcm)), 32'h07);
        cmp(104, "halt7_halted", 32'(halted), 32'd1);
        resume = 1'b1;
        #1;
        cmp(105, "resume_opcode", 32'(opcode), 32'(OP_NOP));
        nxt = next_pc(opcode, instructionValue, pcm);
        @(posedge clock); #1;
        resume = 1'b0;
        pcm = nxt;
        pc  = pcm;
        #1;
        cmp(106, "resume_pc", 32'(pcm), 32'h08);
        cmp(107, "resume_halted", 32'(halted), 32'd0);
        cmp(108, "resume_value", 32'(instructionValue), 32'h88);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; pc = '0; loadEnable = 1'b1; loadValid = 1'b0;
        loadAddr = '0; loadData = '0; resume = 1'b0;
        build_vectors();
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset      = vecs[i].rst;
            pc         = vecs[i].pc;
            loadEnable = vecs[i].le;
            loadValid  = vecs[i].lv;
            loadAddr   = vecs[i].la;
            loadData   = vecs[i].ld;
            resume     = vecs[i].res;
            e.idx = i; e.op = vecs[i].op; e.val = vecs[i].val; e.rs = vecs[i].rs;
            e.rdy = vecs[i].rdy; e.hlt = vecs[i].hlt; e.cnt = vecs[i].cnt;
            sb.push_back(e);
            #1;
            check_top();
            @(posedge clock); #1;
        end
        closed_loop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
